// File: rtl/gl_bram_arbiter.sv
// Purpose: shares one synchronous-read BRAM port between fetch (single word) and decode (1-4 word bursts), round-robin on ties.
// Latency: fetch grant cycle 0 -> fetch_valid cycle 2; decode grant cycle 0 -> dec_valid cycle len+1.
// Backpressure: requesters hold req/addr until their one-cycle gnt; losers and mid-burst arrivals wait; stall covers decode work.
module gl_bram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    input  logic                  dec_req,
    input  logic [ADDR_WIDTH-1:0] dec_addr,
    input  logic [2:0]            dec_len,
    output logic                  dec_gnt,
    output logic [DATA_WIDTH-1:0] dec_data_0,
    output logic [DATA_WIDTH-1:0] dec_data_1,
    output logic [DATA_WIDTH-1:0] dec_data_2,
    output logic [DATA_WIDTH-1:0] dec_data_3,
    output logic                  dec_valid,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  stall
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        F_DATA  = 2'd1,
        D_ISSUE = 2'd2,
        D_DRAIN = 2'd3
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic                                last_was_dec;
    logic [ADDR_WIDTH-1:0]               base_q;
    logic [2:0]                          len_q;
    logic [2:0]                          beat_q;
    logic [2:0]                          dec_len_eff;
    logic [1:0]                          cap_idx;
    logic [MAX_BURST-1:0][DATA_WIDTH-1:0] dec_words;

    assign dec_data_0 = dec_words[0];
    assign dec_data_1 = dec_words[1];
    assign dec_data_2 = dec_words[2];
    assign dec_data_3 = dec_words[3];

    // Normalise the requested burst length: zero means one word, anything above MAX_BURST is clamped.
    always_comb begin
        dec_len_eff = dec_len;
        if (dec_len == 3'd0) begin
            dec_len_eff = 3'd1;
        end else if (dec_len > 3'(MAX_BURST)) begin
            dec_len_eff = 3'(MAX_BURST);
        end
    end

    // Slot of dec_words that receives the word returning from the previous cycle's read.
    always_comb begin
        cap_idx = 2'd0;
        if (state == D_ISSUE) begin
            cap_idx = 2'(beat_q - 3'd1);
        end else if (state == D_DRAIN) begin
            cap_idx = 2'(len_q - 3'd1);
        end
    end

    // Arbitration, BRAM address sequencing, stall and next state; reset forces every combinational output low.
    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        dec_gnt   = 1'b0;
        bram_en   = 1'b0;
        bram_addr = '0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = dec_req;
                if (fetch_req || dec_req) begin
                    bram_en = 1'b1;
                    // Decode wins when alone, or on a tie when fetch won the previous arbitration.
                    if (dec_req && (!fetch_req || !last_was_dec)) begin
                        dec_gnt   = 1'b1;
                        bram_addr = dec_addr;
                        state_nxt = (dec_len_eff == 3'd1) ? D_DRAIN : D_ISSUE;
                    end else begin
                        fetch_gnt = 1'b1;
                        bram_addr = fetch_addr;
                        state_nxt = F_DATA;
                    end
                end
            end
            F_DATA: begin
                state_nxt = IDLE;
            end
            D_ISSUE: begin
                bram_en   = 1'b1;
                bram_addr = base_q + ADDR_WIDTH'(beat_q);
                stall     = 1'b1;
                if (beat_q == (len_q - 3'd1)) begin
                    state_nxt = D_DRAIN;
                end
            end
            D_DRAIN: begin
                stall     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (reset) begin
            state_nxt = IDLE;
            fetch_gnt = 1'b0;
            dec_gnt   = 1'b0;
            bram_en   = 1'b0;
            bram_addr = '0;
            stall     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer and burst bookkeeping: latch base/length at decode grant, advance the beat while issuing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_was_dec <= 1'b1;
            base_q       <= '0;
            len_q        <= 3'd0;
            beat_q       <= 3'd0;
        end else begin
            if (fetch_gnt || dec_gnt) begin
                last_was_dec <= dec_gnt;
            end
            if (dec_gnt) begin
                base_q <= dec_addr;
                len_q  <= dec_len_eff;
                beat_q <= 3'd1;
            end else if (state == D_ISSUE) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // Read-data capture and completion pulses; unused burst words are cleared at grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
            dec_words   <= '0;
            dec_valid   <= 1'b0;
        end else begin
            fetch_valid <= (state == F_DATA);
            dec_valid   <= (state == D_DRAIN);
            if (state == F_DATA) begin
                fetch_data <= bram_rdata;
            end
            if (dec_gnt) begin
                for (int i = 0; i < MAX_BURST; i++) begin
                    if (i >= int'(dec_len_eff)) begin
                        dec_words[i] <= '0;
                    end
                end
            end
            if ((state == D_ISSUE) || (state == D_DRAIN)) begin
                dec_words[cap_idx] <= bram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_gl_bram_arbiter.sv
// Purpose: scoreboard bench for gl_bram_arbiter with a transaction-level reference model and a BRAM responder.
// Latency: expects fetch_valid two cycles after grant, dec_valid len+1 cycles after grant.
// Backpressure: requesters hold until the model's grant; some requests are withdrawn early on purpose.
`timescale 1ns/1ps
module tb_gl_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        dec_req;
    logic [31:0] dec_addr;
    logic [2:0]  dec_len;
    logic        dec_gnt;
    logic [31:0] dec_data_0, dec_data_1, dec_data_2, dec_data_3;
    logic        dec_valid;
    logic        bram_en;
    logic [31:0] bram_addr;
    logic [31:0] bram_rdata;
    logic        stall;

    gl_bram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .dec_req(dec_req), .dec_addr(dec_addr), .dec_len(dec_len), .dec_gnt(dec_gnt),
        .dec_data_0(dec_data_0), .dec_data_1(dec_data_1), .dec_data_2(dec_data_2), .dec_data_3(dec_data_3),
        .dec_valid(dec_valid), .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    // BRAM contents: a few fixed words, hashed contents elsewhere.
    logic [31:0] ovr [logic [31:0]];
    function automatic logic [31:0] memv(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h5A17C0DE;
    endfunction

    // BRAM responder: address seen in cycle N, word presented throughout cycle N+1, junk otherwise.
    logic        en_s;
    logic [31:0] a_s;
    always begin
        @(negedge clk);
        en_s = bram_en;
        a_s  = bram_addr;
        @(posedge clk);
        #1;
        bram_rdata = en_s ? memv(a_s) : $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int vcyc; logic [31:0] d; } fexp_t;
    typedef struct { int vcyc; logic [3:0][31:0] d; } dexp_t;
    fexp_t fq [$];
    dexp_t dq [$];
    logic [31:0] sched [int];
    int  free_at = 0;
    int  dec_busy_end = -1;
    bit  prev_dec = 1'b1;
    bit  m_fgnt = 1'b0;
    bit  m_dgnt = 1'b0;

    // Reference model plus output monitor, evaluated mid-cycle.
    always @(negedge clk) begin : model
        bit          idle;
        bit          exp_stall;
        int          len;
        fexp_t       fe;
        dexp_t       de;
        logic [31:0] a;
        if (reset) begin
            fq.delete();
            dq.delete();
            sched.delete();
            free_at = 0;
            dec_busy_end = -1;
            prev_dec = 1'b1;
            m_fgnt = 1'b0;
            m_dgnt = 1'b0;
            check("rst_fetch_gnt", fetch_gnt, 0);
            check("rst_dec_gnt", dec_gnt, 0);
            check("rst_bram_en", bram_en, 0);
            check("rst_bram_addr", bram_addr, 0);
            check("rst_stall", stall, 0);
            check("rst_fetch_valid", fetch_valid, 0);
            check("rst_dec_valid", dec_valid, 0);
            check("rst_fetch_data", fetch_data, 0);
            check("rst_dec_data", {dec_data_0 | dec_data_1 | dec_data_2 | dec_data_3}, 0);
        end else begin
            idle = (cyc >= free_at);
            exp_stall = (idle && dec_req) || (cyc <= dec_busy_end);
            m_fgnt = 1'b0;
            m_dgnt = 1'b0;
            if (idle && (fetch_req || dec_req)) begin
                if (dec_req && (!fetch_req || !prev_dec)) begin
                    len = (dec_len == 0) ? 1 : ((dec_len > 4) ? 4 : int'(dec_len));
                    de.d = '0;
                    for (int i = 0; i < len; i++) begin
                        a = dec_addr + 32'(i);
                        sched[cyc + i] = a;
                        de.d[i] = memv(a);
                    end
                    de.vcyc = cyc + len + 1;
                    dq.push_back(de);
                    free_at = cyc + len + 1;
                    dec_busy_end = cyc + len;
                    prev_dec = 1'b1;
                    m_dgnt = 1'b1;
                end else begin
                    sched[cyc] = fetch_addr;
                    fe.vcyc = cyc + 2;
                    fe.d = memv(fetch_addr);
                    fq.push_back(fe);
                    free_at = cyc + 2;
                    prev_dec = 1'b0;
                    m_fgnt = 1'b1;
                end
            end
            check("fetch_gnt", fetch_gnt, m_fgnt);
            check("dec_gnt", dec_gnt, m_dgnt);
            check("bram_en", bram_en, sched.exists(cyc));
            if (sched.exists(cyc)) begin
                check("bram_addr", bram_addr, sched[cyc]);
                sched.delete(cyc);
            end else if (idle) begin
                check("bram_addr_idle", bram_addr, 0);
            end
            check("stall", stall, exp_stall);

            if (fetch_valid) begin
                if (fq.size() == 0) begin
                    check("fetch_valid_unexpected", 1, 0);
                end else begin
                    fe = fq.pop_front();
                    check("fetch_valid_cycle", cyc, fe.vcyc);
                    check("fetch_data", fetch_data, fe.d);
                end
            end else if (fq.size() != 0 && fq[0].vcyc <= cyc) begin
                check("fetch_valid_missing", 0, 1);
                void'(fq.pop_front());
            end

            if (dec_valid) begin
                if (dq.size() == 0) begin
                    check("dec_valid_unexpected", 1, 0);
                end else begin
                    de = dq.pop_front();
                    check("dec_valid_cycle", cyc, de.vcyc);
                    check("dec_data_0", dec_data_0, de.d[0]);
                    check("dec_data_1", dec_data_1, de.d[1]);
                    check("dec_data_2", dec_data_2, de.d[2]);
                    check("dec_data_3", dec_data_3, de.d[3]);
                end
            end else if (dq.size() != 0 && dq[0].vcyc <= cyc) begin
                check("dec_valid_missing", 0, 1);
                void'(dq.pop_front());
            end
        end
    end

    // All driver tasks are entered and left just after a rising edge.
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input int maxw, input bit must);
        bit got = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        for (int i = 0; i < maxw; i++) begin
            @(posedge clk);
            if (m_fgnt) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        fetch_req = 1'b0;
        if (must) check("fetch_grant_timeout", got, 1);
    endtask

    task automatic do_dec(input logic [31:0] a, input logic [2:0] l, input int maxw, input bit must);
        bit got = 1'b0;
        dec_req  = 1'b1;
        dec_addr = a;
        dec_len  = l;
        for (int i = 0; i < maxw; i++) begin
            @(posedge clk);
            if (m_dgnt) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        dec_req = 1'b0;
        if (must) check("dec_grant_timeout", got, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        dec_req    = 1'b0;
        dec_addr   = '0;
        dec_len    = '0;
        bram_rdata = '0;
        ovr[32'h10] = 32'hA5A5_0001;
        ovr[32'h20] = 32'd1;
        ovr[32'h21] = 32'd2;
        ovr[32'h22] = 32'd3;
        ovr[32'h23] = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(2);

        // Single fetch, then a full decode burst.
        do_fetch(32'h10, 100, 1);
        idle_cycles(4);
        do_dec(32'h20, 3'd4, 100, 1);
        idle_cycles(8);

        // Simultaneous requests twice: fetch, decode, then fetch again on the next tie.
        fork
            do_fetch(32'h30, 100, 1);
            do_dec(32'h40, 3'd2, 100, 1);
        join
        idle_cycles(6);
        fork
            do_fetch(32'h34, 100, 1);
            do_dec(32'h44, 3'd3, 100, 1);
        join
        idle_cycles(8);

        // Length zero and oversize length at the top of the address space.
        do_dec(32'hFFFF_FFFE, 3'd0, 100, 1);
        idle_cycles(4);
        do_dec(32'hFFFF_FFFE, 3'd7, 100, 1);
        idle_cycles(8);

        // Reset two cycles into a four-word burst, then a clean fetch.
        dec_addr = 32'h40;
        dec_len  = 3'd4;
        dec_req  = 1'b1;
        @(posedge clk);
        #1;
        dec_req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_bram_en", bram_en, 0);
        check("async_rst_stall", stall, 0);
        check("async_rst_bram_addr", bram_addr, 0);
        check("async_rst_dec_data_0", dec_data_0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(8);
        do_fetch(32'h50, 100, 1);
        idle_cycles(6);

        // Randomised traffic from both requesters, with occasional withdrawn requests.
        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    idle_cycles($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) do_fetch(rand_addr(), $urandom_range(1, 2), 0);
                    else do_fetch(rand_addr(), 100, 1);
                end
            end
            begin
                for (int n = 0; n < 150; n++) begin
                    idle_cycles($urandom_range(0, 5));
                    if ($urandom_range(0, 7) == 0) do_dec(rand_addr(), 3'($urandom_range(0, 7)), $urandom_range(1, 2), 0);
                    else do_dec(rand_addr(), 3'($urandom_range(0, 7)), 100, 1);
                end
            end
        join

        idle_cycles(20);
        check("scoreboard_drained", fq.size() + dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
